rtp_rx_depack: RTL and testbench

Receive-side RTP depacketizer. It consumes the UDP receive byte stream from the Ethernet stack, validates the 12-byte RTP header, and unpacks 16-bit big-endian PCM samples into an internal jitter FIFO. The codec playback path drains that FIFO through the `wav_rden`/`wav_out_data` pair. The block is the inverse of the sample→RTP packer on the transmit path and sits between `ethernet_test` and `mywav` in the audio loop top.

---
 rtl/rtp_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/rtp_rx_depack.sv | 241 ++++++++++++++++++++++++
 tb/tb_rtp_rx_depack.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtp_pkg.sv
// -----------------------------------------------------------------------------
// rtp_pkg
// Constants shared by the RTP receive depacketizer and the transmit packer:
// header length, default header/SSRC values, the receive FSM state encoding,
// and a saturating counter increment helper.
// -----------------------------------------------------------------------------
package rtp_pkg;

  localparam int          RTP_HDR_LEN        = 12;
  localparam logic [15:0] RTP_HEADER_DEFAULT = 16'h8080;
  localparam logic [31:0] RTP_SSRC_DEFAULT   = 32'h12345678;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } rx_state_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered read data (first-word latency 1).
// A write while full is accepted only if a read happens in the same cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   wr_en, wr_data write request and data
//   rd_en          read request; rd_data updates on the following cycle
//   rd_data        registered head word (holds between reads)
//   full, empty    occupancy flags derived from level
//   level          number of stored words (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    ONE      = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign do_rd = rd_en && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rtp_rx_depack.sv
// -----------------------------------------------------------------------------
// rtp_rx_depack
// Receive-side RTP depacketizer: parses the UDP payload byte stream, checks
// the 12-byte RTP header, and writes 16-bit big-endian samples into a jitter
// FIFO that the codec drains one sample per wav_rden pulse.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   udp_rec_data_valid    one payload byte on udp_rec_rdata this cycle
//   udp_rec_rdata         received byte
//   udp_rec_data_length   UDP payload length, stable for the whole packet
//   wav_rden              playback request pulse
//   wav_out_data          playback sample, updated the cycle after wav_rden
//   playing               prefill reached, playback active
//   fifo_level            samples currently buffered
//   pkt_ok_cnt .. unf_cnt saturating event counters
//   fsm_state             current parser state (observation only)
// Byte stream handshake: there is no backpressure. Every cycle with
// udp_rec_data_valid high delivers exactly one byte that is consumed in that
// cycle; cycles with valid low are gaps and leave all parser state unchanged.
// -----------------------------------------------------------------------------
module rtp_rx_depack
  import rtp_pkg::*;
#(
  parameter logic [15:0] RTP_Header_Param = RTP_HEADER_DEFAULT,
  parameter logic [31:0] SSRC             = RTP_SSRC_DEFAULT,
  parameter int          FIFO_DEPTH       = 1024,
  parameter int          PREFILL          = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        udp_rec_data_valid,
  input  logic [7:0]                  udp_rec_rdata,
  input  logic [15:0]                 udp_rec_data_length,
  input  logic                        wav_rden,
  output logic [15:0]                 wav_out_data,
  output logic                        playing,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 pkt_ok_cnt,
  output logic [15:0]                 pkt_drop_cnt,
  output logic [15:0]                 seq_err_cnt,
  output logic [15:0]                 ovf_cnt,
  output logic [15:0]                 unf_cnt,
  output rx_state_t                   fsm_state
);

  localparam int          LW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);
  localparam logic [15:0] HDR_LEN     = 16'(RTP_HDR_LEN);
  localparam logic [15:0] HDR_LAST    = HDR_LEN - 16'd1;

  rx_state_t   state;
  logic [15:0] len;
  logic [15:0] byte_cnt;     // index of the byte arriving next
  logic [15:0] seq;
  logic [15:0] prev_seq;
  logic        have_prev;
  logic        bad;
  logic [7:0]  msb;
  logic        out_zero;     // last wav_rden did not pop: present 0

  logic [15:0] cnt_next;
  logic        last;
  logic        byte_bad;
  logic        hdr_done;
  logic        hdr_fail;
  logic        pkt_ok_evt;
  logic        pkt_drop_evt;
  logic        seq_gap;
  logic        push;
  logic        pop;
  logic        ovf_evt;
  logic        unf_evt;
  logic        fifo_full;
  logic        fifo_empty;
  logic [15:0] fifo_rdata;

  // Header byte checks for offsets 1..11 (offset 0 is checked in IDLE).
  always_comb begin
    byte_bad = 1'b0;
    if (byte_cnt == 16'd1) begin
      byte_bad = (udp_rec_rdata[6:0] != RTP_Header_Param[6:0]);
    end else if (byte_cnt == 16'd8) begin
      byte_bad = (udp_rec_rdata != SSRC[31:24]);
    end else if (byte_cnt == 16'd9) begin
      byte_bad = (udp_rec_rdata != SSRC[23:16]);
    end else if (byte_cnt == 16'd10) begin
      byte_bad = (udp_rec_rdata != SSRC[15:8]);
    end else if (byte_cnt == 16'd11) begin
      byte_bad = (udp_rec_rdata != SSRC[7:0]);
    end
  end

  assign cnt_next = byte_cnt + 16'd1;
  assign last     = (cnt_next == len);
  assign hdr_done = udp_rec_data_valid && (state == ST_HDR) && (byte_cnt == HDR_LAST);
  assign hdr_fail = bad || byte_bad;

  assign pkt_ok_evt = (hdr_done && !hdr_fail && last) ||
                      (udp_rec_data_valid && (state == ST_PAYLOAD) && last);
  // A length of 0 or 1 ends the packet on its first byte.
  assign pkt_drop_evt = (udp_rec_data_valid && (state == ST_IDLE) &&
                         (udp_rec_data_length <= 16'd1)) ||
                        (hdr_done && hdr_fail && last) ||
                        (udp_rec_data_valid && (state == ST_DROP) && last);
  assign seq_gap = have_prev && (seq != prev_seq + 16'd1);

  // Payload starts at even offset 12, so odd offsets carry the sample LSB.
  assign push    = udp_rec_data_valid && (state == ST_PAYLOAD) && byte_cnt[0];
  assign pop     = wav_rden && playing && !fifo_empty;
  assign ovf_evt = push && fifo_full && !pop;
  assign unf_evt = wav_rden && playing && fifo_empty;

  // Parser FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      len      <= '0;
      byte_cnt <= '0;
      bad      <= 1'b0;
      seq      <= '0;
      msb      <= '0;
    end else if (udp_rec_data_valid) begin
      case (state)
        ST_IDLE: begin
          len      <= udp_rec_data_length;
          byte_cnt <= 16'd1;
          bad      <= (udp_rec_rdata != RTP_Header_Param[15:8]);
          if (udp_rec_data_length <= 16'd1) begin
            state <= ST_IDLE;
          end else if (udp_rec_data_length < HDR_LEN) begin
            state <= ST_DROP;
          end else begin
            state <= ST_HDR;
          end
        end
        ST_HDR: begin
          byte_cnt <= cnt_next;
          bad      <= hdr_fail;
          if (byte_cnt == 16'd2) begin
            seq[15:8] <= udp_rec_rdata;
          end
          if (byte_cnt == 16'd3) begin
            seq[7:0] <= udp_rec_rdata;
          end
          if (byte_cnt == HDR_LAST) begin
            if (last) begin
              state <= ST_IDLE;
            end else if (hdr_fail) begin
              state <= ST_DROP;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          byte_cnt <= cnt_next;
          if (!byte_cnt[0]) begin
            msb <= udp_rec_rdata;
          end
          if (last) begin
            state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          byte_cnt <= cnt_next;
          if (last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Event counters and sequence history
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
      seq_err_cnt  <= '0;
      ovf_cnt      <= '0;
      unf_cnt      <= '0;
      prev_seq     <= '0;
      have_prev    <= 1'b0;
    end else begin
      if (pkt_ok_evt) begin
        pkt_ok_cnt <= sat_inc(pkt_ok_cnt);
        prev_seq   <= seq;
        have_prev  <= 1'b1;
        if (seq_gap) begin
          seq_err_cnt <= sat_inc(seq_err_cnt);
        end
      end
      if (pkt_drop_evt) begin
        pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
      end
      if (ovf_evt) begin
        ovf_cnt <= sat_inc(ovf_cnt);
      end
      if (unf_evt) begin
        unf_cnt <= sat_inc(unf_cnt);
      end
    end
  end

  // Playback control
  always_ff @(posedge clk) begin
    if (rst) begin
      playing  <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      if (wav_rden) begin
        out_zero <= !pop;
      end
      if (unf_evt) begin
        playing <= 1'b0;
      end else if (fifo_level >= PREFILL_LVL) begin
        playing <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({msb, udp_rec_rdata}),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign wav_out_data = out_zero ? 16'h0000 : fifo_rdata;
  assign fsm_state    = state;

endmodule

// File: tb/tb_rtp_rx_depack.sv
// -----------------------------------------------------------------------------
// tb_rtp_rx_depack
// Directed sequence with randomized payloads and header corruption. Expected
// values come from a packet-level reference model: each packet is judged as
// a whole from its bytes, samples go into an expected queue, and playback
// reads pop that queue.
// -----------------------------------------------------------------------------
module tb_rtp_rx_depack;
  import rtp_pkg::*;

  localparam int          DEPTH   = 2048;
  localparam int          PREFILL = 512;
  localparam logic [15:0] HDR     = 16'h8080;
  localparam logic [31:0] SSRC_V  = 32'h12345678;
  localparam int          LW      = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [7:0]    rdata;
  logic [15:0]   length;
  logic          wav_rden;
  logic [15:0]   wav_out_data;
  logic          playing;
  logic [LW-1:0] fifo_level;
  logic [15:0]   pkt_ok_cnt, pkt_drop_cnt, seq_err_cnt, ovf_cnt, unf_cnt;
  rx_state_t     fsm_state;

  always #10 clk = ~clk;

  rtp_rx_depack #(
    .RTP_Header_Param (HDR),
    .SSRC             (SSRC_V),
    .FIFO_DEPTH       (DEPTH),
    .PREFILL          (PREFILL)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .udp_rec_data_valid  (valid),
    .udp_rec_rdata       (rdata),
    .udp_rec_data_length (length),
    .wav_rden            (wav_rden),
    .wav_out_data        (wav_out_data),
    .playing             (playing),
    .fifo_level          (fifo_level),
    .pkt_ok_cnt          (pkt_ok_cnt),
    .pkt_drop_cnt        (pkt_drop_cnt),
    .seq_err_cnt         (seq_err_cnt),
    .ovf_cnt             (ovf_cnt),
    .unf_cnt             (unf_cnt),
    .fsm_state           (fsm_state)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [15:0] exp_q[$];
  logic [7:0]  pkt_q[$];
  int unsigned m_ok, m_drop, m_seq, m_ovf, m_unf;
  bit          m_playing, m_have_prev;
  logic [15:0] m_prev;
  logic [15:0] seq_no;
  int          tests_run = 0;
  int          fail_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ok = 0; m_drop = 0; m_seq = 0; m_ovf = 0; m_unf = 0;
    m_playing = 1'b0; m_have_prev = 1'b0; m_prev = '0;
  endtask

  // Judge a packet of len bytes (pkt_q[0..len-1]) from its header fields.
  task automatic model_pkt(input int len);
    logic [15:0] h;
    logic [7:0]  b1;
    logic [15:0] s;
    logic [15:0] pseq;
    bit          good;
    h = HDR;
    if (len < 12) begin
      m_drop++;
      return;
    end
    b1   = pkt_q[1];
    good = (pkt_q[0] == h[15:8]) && (b1[6:0] == h[6:0]) &&
           ({pkt_q[8], pkt_q[9], pkt_q[10], pkt_q[11]} == SSRC_V);
    if (!good) begin
      m_drop++;
      return;
    end
    m_ok++;
    pseq = {pkt_q[2], pkt_q[3]};
    if (m_have_prev && (pseq != 16'(m_prev + 16'd1))) m_seq++;
    m_prev      = pseq;
    m_have_prev = 1'b1;
    for (int i = 0; i < (len - 12) / 2; i++) begin
      s = {pkt_q[12 + 2*i], pkt_q[13 + 2*i]};
      if (exp_q.size() < DEPTH) exp_q.push_back(s);
      else m_ovf++;
    end
    if (exp_q.size() >= PREFILL) m_playing = 1'b1;
  endtask

  // ---------------- packet construction ----------------
  task automatic build_pkt(input logic [15:0] seq, input logic [31:0] ssrc, input int nsamp,
                           input bit ramp, input bit odd_tail);
    logic [15:0] h;
    logic [15:0] s;
    h = HDR;
    pkt_q.delete();
    pkt_q.push_back(h[15:8]);
    pkt_q.push_back({1'($urandom_range(0, 1)), h[6:0]});   // random marker bit
    pkt_q.push_back(seq[15:8]);
    pkt_q.push_back(seq[7:0]);
    for (int i = 0; i < 4; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
    pkt_q.push_back(ssrc[31:24]);
    pkt_q.push_back(ssrc[23:16]);
    pkt_q.push_back(ssrc[15:8]);
    pkt_q.push_back(ssrc[7:0]);
    for (int i = 0; i < nsamp; i++) begin
      s = ramp ? 16'(i) : 16'($urandom_range(0, 65535));
      pkt_q.push_back(s[15:8]);
      pkt_q.push_back(s[7:0]);
    end
    if (odd_tail) pkt_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic corrupt_hdr();
    int pick;
    int idx;
    pick = $urandom_range(0, 5);
    idx  = (pick < 2) ? pick : pick + 6;   // offsets 0, 1, 8..11
    if (idx == 1) pkt_q[1] = pkt_q[1] ^ {1'b0, 7'($urandom_range(1, 127))};
    else          pkt_q[idx] = pkt_q[idx] ^ 8'($urandom_range(1, 255));
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        valid = 1'b0;
      end
      @(negedge clk);
      valid = 1'b1;
      rdata = pkt_q[i];
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic send_pkt(input int len);
    length = 16'(len);
    send_bytes(len);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_read(input string tag);
    logic [15:0] e;
    if (m_playing && exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = 16'h0000;
      if (m_playing) begin
        m_unf++;
        m_playing = 1'b0;
      end
    end
    @(negedge clk);
    wav_rden = 1'b1;
    @(negedge clk);
    wav_rden = 1'b0;
    chk(tag, 32'(wav_out_data), 32'(e));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    valid    = 1'b0;
    wav_rden = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/pkt_ok"},   32'(pkt_ok_cnt),   32'(m_ok));
    chk({tag, "/pkt_drop"}, 32'(pkt_drop_cnt), 32'(m_drop));
    chk({tag, "/seq_err"},  32'(seq_err_cnt),  32'(m_seq));
    chk({tag, "/ovf"},      32'(ovf_cnt),      32'(m_ovf));
    chk({tag, "/unf"},      32'(unf_cnt),      32'(m_unf));
    chk({tag, "/level"},    32'(fifo_level),   32'(exp_q.size()));
    chk({tag, "/playing"},  32'(playing),      32'(m_playing));
    chk({tag, "/state"},    32'(fsm_state),    32'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; valid = 1'b0; rdata = '0; length = '0; wav_rden = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset/wav_out", 32'(wav_out_data), 32'h0);
    check_all("reset");

    // Valid packet, seq 5, ramp 0x0000..0x01DF (len 972)
    build_pkt(16'd5, SSRC_V, 480, 1'b1, 1'b0);
    chk("pkt1/len", 32'(pkt_q.size()), 32'd972);
    model_pkt(pkt_q.size()); send_pkt(pkt_q.size());
    check_all("pkt1");

    // Below prefill: reads return 0 and do not pop
    repeat (3) do_read("prefill_rd");
    check_all("prefill");

    // Wrong SSRC is dropped
    build_pkt(16'd6, 32'h12345679, 480, 1'b0, 1'b0);
    model_pkt(pkt_q.size()); send_pkt(pkt_q.size());
    check_all("bad_ssrc");

    // seq 6 brings the level to exactly PREFILL; seq 7 then 9 (gap)
    build_pkt(16'd6, SSRC_V, 32, 1'b0, 1'b0);
    model_pkt(pkt_q.size()); send_pkt(pkt_q.size());
    check_all("at_prefill");
    build_pkt(16'd7, SSRC_V, 448, 1'b0, 1'b0);
    model_pkt(pkt_q.size()); send_pkt(pkt_q.size());
    build_pkt(16'd9, SSRC_V, 480, 1'b0, 1'b0);
    model_pkt(pkt_q.size()); send_pkt(pkt_q.size());
    check_all("seq_gap");

    // Drain everything plus one extra read (underflow)
    for (int i = 0; i < 1441; i++) do_read("drain_rd");
    check_all("drain");

    // Short packet (len 8), length 1, header-only (len 12)
    build_pkt(16'd10, SSRC_V, 0, 1'b0, 1'b0);
    while (pkt_q.size() > 8) void'(pkt_q.pop_back());
    model_pkt(8); send_pkt(8);
    check_all("short8");
    build_pkt(16'd10, SSRC_V, 0, 1'b0, 1'b0);
    model_pkt(1); send_pkt(1);
    build_pkt(16'd10, SSRC_V, 0, 1'b0, 1'b0);
    model_pkt(12); send_pkt(12);
    check_all("hdr_only");

    // Corrupted headers are dropped
    for (int i = 0; i < 4; i++) begin
      build_pkt(16'd11, SSRC_V, 10, 1'b0, 1'b0);
      corrupt_hdr();
      model_pkt(pkt_q.size()); send_pkt(pkt_q.size());
    end
    check_all("corrupt");

    // Overflow: 4 x 480 + 131 (+ trailing odd byte) = DEPTH + 3 samples
    seq_no = 16'd11;
    for (int i = 0; i < 4; i++) begin
      build_pkt(seq_no, SSRC_V, 480, 1'b0, 1'b0);
      model_pkt(pkt_q.size()); send_pkt(pkt_q.size());
      seq_no = seq_no + 16'd1;
    end
    build_pkt(seq_no, SSRC_V, 131, 1'b0, 1'b1);
    model_pkt(pkt_q.size()); send_pkt(pkt_q.size());
    check_all("overflow");
    chk("overflow/level_full", 32'(fifo_level), 32'(DEPTH));
    chk("overflow/ovf3", 32'(ovf_cnt), 32'd3);

    // Reset in the middle of a payload
    build_pkt(16'd50, SSRC_V, 100, 1'b0, 1'b0);
    length = 16'(pkt_q.size());
    send_bytes(40);
    do_reset();
    chk("mid_rst/wav_out", 32'(wav_out_data), 32'h0);
    check_all("mid_rst");

    // Leftover bytes of the abandoned packet parse as a new bad packet
    for (int i = 0; i < 40; i++) void'(pkt_q.pop_front());
    while (pkt_q.size() > 20) void'(pkt_q.pop_back());
    pkt_q[0] = 8'h11;
    model_pkt(20); send_pkt(20);
    check_all("stale");

    // Fresh packet after reset: accepted, no sequence error
    build_pkt(16'd100, SSRC_V, 60, 1'b0, 1'b0);
    model_pkt(pkt_q.size()); send_pkt(pkt_q.size());
    check_all("post_rst");

    // Randomized packets: sizes, seq steps, odd tails, corruption
    seq_no = 16'd101;
    for (int i = 0; i < 6; i++) begin
      build_pkt(seq_no, SSRC_V, $urandom_range(0, 120), 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) corrupt_hdr();
      model_pkt(pkt_q.size()); send_pkt(pkt_q.size());
      seq_no = seq_no + (($urandom_range(0, 3) == 0) ? 16'($urandom_range(2, 9)) : 16'd1);
    end
    check_all("rand");
    begin
      int n;
      n = exp_q.size() + 2;
      for (int i = 0; i < n; i++) do_read("rand_rd");
    end
    check_all("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
